// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: main control FSM of a multicycle RISC datapath.
// One instruction moves through FETCH, DECODE and an opcode-specific tail of
// states. Memory states wait on mem_ready_i. Illegal opcodes retire directly
// from DECODE and set a sticky flag. Control strobes are pure decodes of the
// current state, so an asynchronous reset silences them at once.
module rv_multicycle_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [5:0]  Op_i,
    input  logic        mem_ready_i,
    output logic        PCWrite_o,
    output logic        PCWriteCond_o,
    output logic        IorD_o,
    output logic        MemRead_o,
    output logic        MemWrite_o,
    output logic        IRWrite_o,
    output logic        MemtoReg_o,
    output logic        RegDst_o,
    output logic        RegWrite_o,
    output logic        ALUSrcA_o,
    output logic [1:0]  ALUSrcB_o,
    output logic [1:0]  ALUOp_o,
    output logic [1:0]  PCSource_o,
    output logic [3:0]  state_o,
    output logic        illegal_o,
    output logic [31:0] instr_cnt_o
);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_EXEC   = 4'd7,
        ST_RWB    = 4'd8,
        ST_BRANCH = 4'd9,
        ST_JUMP   = 4'd10,
        ST_ADDI   = 4'd11,
        ST_ADDIWB = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t      state_r;
    state_t      next_state_s;
    state_t      after_retire_s;
    logic        retire_s;
    logic        illegal_set_s;
    logic        illegal_r;
    logic [31:0] instr_cnt_r;

    assign state_o     = state_r;
    assign illegal_o   = illegal_r;
    assign instr_cnt_o = instr_cnt_r;

    // Where the FSM goes once an instruction retires: keep running or park.
    always_comb begin
        if (start_i) begin
            after_retire_s = ST_FETCH;
        end else begin
            after_retire_s = ST_IDLE;
        end
    end

    // Next-state, retirement and control-strobe decode of the current state.
    always_comb begin
        next_state_s  = state_r;
        retire_s      = 1'b0;
        illegal_set_s = 1'b0;
        PCWrite_o     = 1'b0;
        PCWriteCond_o = 1'b0;
        IorD_o        = 1'b0;
        MemRead_o     = 1'b0;
        MemWrite_o    = 1'b0;
        IRWrite_o     = 1'b0;
        MemtoReg_o    = 1'b0;
        RegDst_o      = 1'b0;
        RegWrite_o    = 1'b0;
        ALUSrcA_o     = 1'b0;
        ALUSrcB_o     = 2'b00;
        ALUOp_o       = 2'b00;
        PCSource_o    = 2'b00;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                MemRead_o = 1'b1;
                ALUSrcB_o = 2'b01;
                IRWrite_o = mem_ready_i;
                PCWrite_o = mem_ready_i;
                if (mem_ready_i) begin
                    next_state_s = ST_DECODE;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                ALUSrcB_o = 2'b11;
                case (Op_i)
                    OP_RTYPE: next_state_s = ST_EXEC;
                    OP_ADDI:  next_state_s = ST_ADDI;
                    OP_LW:    next_state_s = ST_MEMADR;
                    OP_SW:    next_state_s = ST_MEMADR;
                    OP_BEQ:   next_state_s = ST_BRANCH;
                    OP_J:     next_state_s = ST_JUMP;
                    default: begin
                        // Unknown opcode: flag it and retire with no datapath effect.
                        illegal_set_s = 1'b1;
                        retire_s      = 1'b1;
                        next_state_s  = after_retire_s;
                    end
                endcase
            end
            ST_MEMADR: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                if (Op_i == OP_LW) begin
                    next_state_s = ST_MEMRD;
                end else begin
                    next_state_s = ST_MEMWR;
                end
            end
            ST_MEMRD: begin
                MemRead_o = 1'b1;
                IorD_o    = 1'b1;
                if (mem_ready_i) begin
                    next_state_s = ST_MEMWB;
                end else begin
                    next_state_s = ST_MEMRD;
                end
            end
            ST_MEMWB: begin
                RegWrite_o   = 1'b1;
                MemtoReg_o   = 1'b1;
                retire_s     = 1'b1;
                next_state_s = after_retire_s;
            end
            ST_MEMWR: begin
                MemWrite_o = 1'b1;
                IorD_o     = 1'b1;
                if (mem_ready_i) begin
                    retire_s     = 1'b1;
                    next_state_s = after_retire_s;
                end else begin
                    next_state_s = ST_MEMWR;
                end
            end
            ST_EXEC: begin
                ALUSrcA_o    = 1'b1;
                ALUOp_o      = 2'b10;
                next_state_s = ST_RWB;
            end
            ST_RWB: begin
                RegDst_o     = 1'b1;
                RegWrite_o   = 1'b1;
                retire_s     = 1'b1;
                next_state_s = after_retire_s;
            end
            ST_ADDI: begin
                ALUSrcA_o    = 1'b1;
                ALUSrcB_o    = 2'b10;
                next_state_s = ST_ADDIWB;
            end
            ST_ADDIWB: begin
                RegWrite_o   = 1'b1;
                retire_s     = 1'b1;
                next_state_s = after_retire_s;
            end
            ST_BRANCH: begin
                ALUSrcA_o     = 1'b1;
                ALUOp_o       = 2'b01;
                PCWriteCond_o = 1'b1;
                PCSource_o    = 2'b01;
                retire_s      = 1'b1;
                next_state_s  = after_retire_s;
            end
            ST_JUMP: begin
                PCWrite_o    = 1'b1;
                PCSource_o   = 2'b10;
                retire_s     = 1'b1;
                next_state_s = after_retire_s;
            end
            default: begin
                // Unused encodings recover to IDLE.
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register, retired-instruction counter and sticky illegal flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            instr_cnt_r <= 32'd0;
            illegal_r   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (retire_s) begin
                instr_cnt_r <= instr_cnt_r + 32'd1;
            end
            if (illegal_set_s) begin
                illegal_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Self-checking bench for rv_multicycle_ctrl: directed scenarios followed by
// randomized traffic, all compared against an instruction-level model that
// tracks each instruction as a list of states to visit.
module tb_rv_multicycle_ctrl;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ILL  = 6'b111111;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [5:0]  Op_i;
    logic        mem_ready_i;
    logic        PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o;
    logic        IRWrite_o, MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o;
    logic [1:0]  ALUSrcB_o, ALUOp_o, PCSource_o;
    logic [3:0]  state_o;
    logic        illegal_o;
    logic [31:0] instr_cnt_o;
    logic [15:0] ctrl_s;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: current instruction as a list of states plus position.
    int          m_path[$];
    int          m_pos;
    bit          m_idle;
    logic        m_ill;
    logic [31:0] m_cnt;

    rv_multicycle_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .Op_i(Op_i),
        .mem_ready_i(mem_ready_i), .PCWrite_o(PCWrite_o), .PCWriteCond_o(PCWriteCond_o),
        .IorD_o(IorD_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
        .IRWrite_o(IRWrite_o), .MemtoReg_o(MemtoReg_o), .RegDst_o(RegDst_o),
        .RegWrite_o(RegWrite_o), .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o),
        .ALUOp_o(ALUOp_o), .PCSource_o(PCSource_o), .state_o(state_o),
        .illegal_o(illegal_o), .instr_cnt_o(instr_cnt_o)
    );

    // 10-unit clock.
    always #5 clk_i = ~clk_i;

    assign ctrl_s = {PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
                     MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, PCSource_o};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Control word each state must present, straight from the state table.
    function automatic logic [15:0] exp_ctrl(input int st, input logic mr);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa;
        logic [1:0] sb, ao, ps;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa} = 10'd0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        case (st)
            1:  begin mrd = 1'b1; sb = 2'b01; irw = mr; pcw = mr; end
            2:  sb = 2'b11;
            3:  begin sa = 1'b1; sb = 2'b10; end
            4:  begin mrd = 1'b1; iord = 1'b1; end
            5:  begin rw = 1'b1; m2r = 1'b1; end
            6:  begin mwr = 1'b1; iord = 1'b1; end
            7:  begin sa = 1'b1; ao = 2'b10; end
            8:  begin rdst = 1'b1; rw = 1'b1; end
            9:  begin sa = 1'b1; ao = 2'b01; pcwc = 1'b1; ps = 2'b01; end
            10: begin pcw = 1'b1; ps = 2'b10; end
            11: begin sa = 1'b1; sb = 2'b10; end
            12: rw = 1'b1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb, ao, ps};
    endfunction

    function automatic int exp_state();
        if (m_idle) return 0;
        return m_path[m_pos];
    endfunction

    task automatic model_reset();
        m_path.delete();
        m_pos  = 0;
        m_idle = 1'b1;
        m_ill  = 1'b0;
        m_cnt  = 32'd0;
    endtask

    task automatic start_instr();
        m_path.delete();
        m_path.push_back(1);
        m_path.push_back(2);
        m_pos  = 0;
        m_idle = 1'b0;
    endtask

    // Advance the model by one clock edge given the inputs seen at that edge.
    task automatic model_advance(input logic st, input logic mr, input logic [5:0] op);
        int cur;
        if (m_idle) begin
            if (st) start_instr();
        end else begin
            cur = m_path[m_pos];
            if (!((cur == 1 || cur == 4 || cur == 6) && !mr)) begin
                if (cur == 2) begin
                    case (op)
                        OP_R:    begin m_path.push_back(7);  m_path.push_back(8);  end
                        OP_ADDI: begin m_path.push_back(11); m_path.push_back(12); end
                        OP_LW:   begin m_path.push_back(3);  m_path.push_back(4); m_path.push_back(5); end
                        OP_SW:   begin m_path.push_back(3);  m_path.push_back(6);  end
                        OP_BEQ:  m_path.push_back(9);
                        OP_J:    m_path.push_back(10);
                        default: m_ill = 1'b1;
                    endcase
                end
                if (m_pos == m_path.size() - 1) begin
                    m_cnt = m_cnt + 32'd1;
                    if (st) start_instr();
                    else m_idle = 1'b1;
                end else begin
                    m_pos++;
                end
            end
        end
    endtask

    // One cycle: drive inputs just after negedge, compare, then advance model.
    task automatic step(input logic st, input logic mr, input logic [5:0] op);
        int es;
        start_i = st; mem_ready_i = mr; Op_i = op;
        #1;
        es = exp_state();
        check_eq("state", 32'(state_o), 32'(es));
        check_eq("ctrl", 32'(ctrl_s), 32'(exp_ctrl(es, mr)));
        check_eq("illegal", 32'(illegal_o), 32'(m_ill));
        check_eq("instr_cnt", instr_cnt_o, m_cnt);
        model_advance(st, mr, op);
        @(negedge clk_i);
    endtask

    // Pulse reset across a clock edge, checking outputs stay cleared.
    task automatic do_reset();
        rst_i = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            check_eq("rst_state", 32'(state_o), 32'd0);
            check_eq("rst_ctrl", 32'(ctrl_s), 32'd0);
            check_eq("rst_cnt", instr_cnt_o, 32'd0);
            check_eq("rst_illegal", 32'(illegal_o), 32'd0);
            @(negedge clk_i);
        end
        rst_i = 1'b0;
    endtask

    function automatic logic [5:0] rand_op();
        case ($urandom_range(0, 7))
            0: return OP_R;
            1: return OP_ADDI;
            2: return OP_LW;
            3: return OP_SW;
            4: return OP_BEQ;
            5: return OP_J;
            default: return 6'($urandom_range(0, 63));
        endcase
    endfunction

    initial begin
        logic [5:0] op;
        logic st, mr;
        start_i = 1'b0; mem_ready_i = 1'b0; Op_i = 6'd0; rst_i = 1'b1;
        model_reset();
        @(negedge clk_i);
        do_reset();

        // lw with memory always ready: 0,1,2,3,4,5 then FETCH.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, OP_LW);
        check_eq("lw_cnt", instr_cnt_o, 32'd1);
        check_eq("lw_back_fetch", 32'(state_o), 32'd1);

        // FETCH waits two cycles, then sw with a three-cycle MEMWR wait.
        step(1'b1, 1'b0, OP_SW);
        step(1'b1, 1'b0, OP_SW);
        step(1'b1, 1'b1, OP_SW);
        step(1'b1, 1'b1, OP_SW);
        step(1'b1, 1'b1, OP_SW);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, OP_SW);
        step(1'b1, 1'b1, OP_SW);
        check_eq("sw_cnt", instr_cnt_o, 32'd2);

        // Illegal opcode: retires from DECODE, flag is sticky.
        step(1'b1, 1'b1, OP_ILL);
        step(1'b1, 1'b1, OP_ILL);
        check_eq("ill_flag", 32'(illegal_o), 32'd1);
        check_eq("ill_cnt", instr_cnt_o, 32'd3);

        // Jump ending with start low, then counter wrap on an R-type whose
        // start is dropped during EXEC.
        step(1'b1, 1'b1, OP_J);
        step(1'b1, 1'b1, OP_J);
        step(1'b0, 1'b1, OP_J);
        dut.instr_cnt_r = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        step(1'b0, 1'b1, OP_R);
        step(1'b1, 1'b1, OP_R);
        step(1'b1, 1'b1, OP_R);
        step(1'b1, 1'b1, OP_R);
        step(1'b0, 1'b1, OP_R);
        step(1'b0, 1'b1, OP_R);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 6'($urandom_range(0, 63)));
        check_eq("wrap_cnt", instr_cnt_o, 32'd0);
        check_eq("wrap_idle", 32'(state_o), 32'd0);

        // Asynchronous reset in the middle of a MEMRD wait.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, OP_LW);
        step(1'b1, 1'b0, OP_LW);
        start_i = 1'b1; mem_ready_i = 1'b0;
        #1;
        check_eq("pre_rst_memrd", 32'(state_o), 32'd4);
        #1;
        rst_i = 1'b1;
        #1;
        check_eq("async_rst_state", 32'(state_o), 32'd0);
        check_eq("async_rst_memread", 32'(MemRead_o), 32'd0);
        check_eq("async_rst_cnt", instr_cnt_o, 32'd0);
        check_eq("async_rst_illegal", 32'(illegal_o), 32'd0);
        @(negedge clk_i);
        do_reset();

        // Randomized traffic with occasional resets.
        op = OP_R;
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 699) begin
                do_reset();
            end else begin
                if (exp_state() <= 1) op = rand_op();
                st = ($urandom_range(0, 7) != 0);
                mr = ($urandom_range(0, 3) != 0);
                step(st, mr, op);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rv_multicycle_ctrl.md
RV_MULTICYCLE_CTRL -- requirements
Module: rv_multicycle_ctrl

Interface
REQ-001 The block SHALL have a single clock domain: one clock, reset asynchronous and active-high.
REQ-002 The ports SHALL be (name, direction, width, meaning), one per line:
- clk_i  in  1  clock, rising-edge
- rst_i  in  1  asynchronous active-high reset
- start_i  in  1  run enable
- Op_i  in  6  opcode field of IR; stable from DECODE until next FETCH
- mem_ready_i  in  1  memory access complete this cycle
- PCWrite_o  out  1  unconditional PC load
- PCWriteCond_o  out  1  PC load if ALU zero
- IorD_o  out  1  memory address select (0 = PC, 1 = ALUOut)
- MemRead_o  out  1  memory read strobe
- MemWrite_o  out  1  memory write strobe
- IRWrite_o  out  1  instruction register load
- MemtoReg_o  out  1  write-back select (1 = MDR)
- RegDst_o  out  1  destination select (1 = rd, 0 = rt)
- RegWrite_o  out  1  register file write
- ALUSrcA_o  out  1  ALU A select (0 = PC, 1 = A)
- ALUSrcB_o  out  2  ALU B select (00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2)
- ALUOp_o  out  2  00 add, 01 sub, 10 funct-decoded
- PCSource_o  out  2  00 ALU, 01 ALUOut, 10 jump target
- state_o  out  4  current state encoding
- illegal_o  out  1  sticky illegal-opcode flag
- instr_cnt_o  out  32  retired instruction count

Function
REQ-003 The FSM SHALL use these state encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RWB=8, BRANCH=9, JUMP=10, ADDI=11, ADDIWB=12; codes 13-15 SHALL return to IDLE on the next clock.
REQ-004 Every control output not listed for a state SHALL be 0 in that state; all control outputs SHALL be combinational decodes of state, plus mem_ready_i where stated.
REQ-005 IDLE SHALL go to FETCH when start_i=1, else remain in IDLE.
REQ-006 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00 and IRWrite=PCWrite=mem_ready_i; it SHALL hold in FETCH while mem_ready_i=0 and go to DECODE when it is 1.
REQ-007 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00 and transition by Op_i as follows:
- 000000 -> EXEC
- 001000 -> ADDI
- 100011 or 101011 -> MEMADR
- 000100 -> BRANCH
- 000010 -> JUMP
- any other opcode -> illegal-opcode handling (REQ-013)
REQ-008 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00 and go to MEMRD for opcode 100011, else to MEMWR.
REQ-009 MEMRD SHALL drive MemRead=1, IorD=1, hold while mem_ready_i=0, then go to MEMWB.
REQ-010 MEMWB SHALL drive RegWrite=1, MemtoReg=1, RegDst=0; MEMWR SHALL drive MemWrite=1, IorD=1 and hold while mem_ready_i=0.
REQ-011 The execute states SHALL drive the following:
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next state RWB.
- RWB: RegDst=1, RegWrite=1.
- ADDI: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state ADDIWB.
- ADDIWB: RegDst=0, RegWrite=1.
REQ-012 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; JUMP SHALL drive PCWrite=1, PCSource=10.
REQ-013 On an illegal opcode in DECODE, illegal_o SHALL be set on that clock edge and remain 1 until reset; the instruction SHALL retire without side effects.
REQ-014 The terminal states SHALL be MEMWB, RWB, ADDIWB, BRANCH, JUMP, MEMWR (on mem_ready_i=1), and DECODE on an illegal opcode.
REQ-015 On leaving a terminal state, instr_cnt_o SHALL increment by 1 (modulo 2^32, wrapping 0xFFFFFFFF -> 0) and the FSM SHALL go to FETCH if start_i=1, else to IDLE.
REQ-016 Deasserting start_i mid-instruction SHALL NOT abort the instruction; it SHALL complete and then the FSM SHALL enter IDLE.
REQ-017 mem_ready_i SHALL be ignored in all states other than FETCH, MEMRD and MEMWR.
REQ-018 Cycle counts with mem_ready_i held at 1 SHALL be:
- R-type: 4
- addi: 4
- lw: 5
- sw: 4
- beq: 3
- j: 3
- illegal: 2

Reset
REQ-019 While rst_i=1, regardless of clock, the block SHALL hold state=IDLE, illegal_o=0 and instr_cnt_o=0, with all control outputs therefore 0.
REQ-020 Reset asserted mid-instruction, including during a memory wait, SHALL abandon the instruction with no further strobes.
REQ-021 After rst_i falls, the first transition SHALL occur on the next rising clk_i edge and SHALL obey REQ-005.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset, start_i=1, Op_i=100011, mem_ready_i=1 -> state sequence 1,2,3,4,5,1; IRWrite=1 only in the FETCH cycle; RegWrite=MemtoReg=1 only in MEMWB; instr_cnt_o=1.
- sw with mem_ready_i=0 for 3 cycles in MEMWR -> MemWrite=IorD=1 for 4 cycles; state 6 held; then FETCH; instr_cnt_o increments once.
- FETCH with mem_ready_i low for 2 cycles -> MemRead=1 for 3 cycles; IRWrite/PCWrite=1 only in the 3rd cycle.
- Op_i=111111 at DECODE -> illegal_o=1 from the next edge and sticky; next state FETCH; instr_cnt_o=1; no RegWrite, MemWrite or PCWriteCond pulses.
- start_i dropped during EXEC -> RWB completes (RegWrite pulse), then IDLE; outputs 0 while idle; instr_cnt_o preset-by-run to 0xFFFFFFFF wraps to 0.
- rst_i pulsed asynchronously mid-MEMRD -> state_o=0 immediately, before the next clock; MemRead drops; counters cleared.
